pipe_ctrl: RTL and testbench



---
 rtl/pipe_pkg.sv | 18 +
 rtl/md_sequencer.sv | 47 ++++
 rtl/pipe_ctrl.sv | 76 +++++++
 tb/tb_pipe_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings for the pipeline hazard and flush controller
package pipe_pkg;

  localparam logic [1:0]  TUSE_NONE = 2'd3;
  localparam logic [1:0]  TNEW_NOW  = 2'd0;
  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [4:0]  EPC_REG   = 5'd14;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  // Register 0 never carries a dependency; a dst of 0 therefore never matches.
  function automatic logic raw_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] dst, input logic [1:0] tnew);
    return (src != REG_ZERO) && (src == dst) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multiply/divide busy counter; built only with PIPE_CTRL_MDU_EN
module md_sequencer
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  input  logic flush,
  output logic md_busy
);

`ifdef PIPE_CTRL_MDU_EN
  localparam int CNT_W = 16;

  md_state_t        state;
  logic [CNT_W-1:0] md_cnt;

  // A start in a flush cycle belongs to an instruction being discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MD_IDLE;
      md_cnt <= '0;
    end else if (start && !flush) begin
      state  <= MD_BUSY;
      md_cnt <= div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (state == MD_BUSY) begin
      if (md_cnt == CNT_W'(1)) begin
        state  <= MD_IDLE;
        md_cnt <= '0;
      end else begin
        md_cnt <= md_cnt - CNT_W'(1);
      end
    end
  end

  assign md_busy = !reset && (start || (md_cnt != '0));
`else
  logic unused_md;
  assign unused_md = ^{clk, reset, start, div, flush};
  assign md_busy   = 1'b0;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush controller for the five-stage pipeline
// MDU sequencer and MDU stall term present only with PIPE_CTRL_MDU_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic [4:0]  E_RegAddr,
  input  logic [4:0]  M_RegAddr,
  input  logic [1:0]  E_Tnew,
  input  logic [1:0]  M_Tnew,
  input  logic        D_is_md,
  input  logic        E_md_start,
  input  logic        E_md_div,
  input  logic        D_eret,
  input  logic        E_mtc0_epc,
  input  logic        M_mtc0_epc,
  input  logic        M_req,
  output logic        stall,
  output logic        req,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic raw_stall;
  logic mdu_stall;
  logic eret_stall;

  assign raw_stall = raw_hazard(D_rs, D_Tuse_rs, E_RegAddr, E_Tnew)
                   | raw_hazard(D_rs, D_Tuse_rs, M_RegAddr, M_Tnew)
                   | raw_hazard(D_rt, D_Tuse_rt, E_RegAddr, E_Tnew)
                   | raw_hazard(D_rt, D_Tuse_rt, M_RegAddr, M_Tnew);

  // eret must read the EPC value an in-flight mtc0 is about to write.
  assign eret_stall = D_eret && (E_mtc0_epc || M_mtc0_epc);

  md_sequencer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_sequencer (
    .clk    (clk),
    .reset  (reset),
    .start  (E_md_start),
    .div    (E_md_div),
    .flush  (M_req),
    .md_busy(md_busy)
  );

`ifdef PIPE_CTRL_MDU_EN
  assign mdu_stall = D_is_md && md_busy;
`else
  logic unused_d_md;
  assign unused_d_md = D_is_md;
  assign mdu_stall   = 1'b0;
`endif

  // A flush discards D anyway, so it overrides any stall.
  assign req   = !reset && M_req;
  assign stall = !reset && !M_req && (raw_stall || mdu_stall || eret_stall);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - bench for pipe_ctrl, follows PIPE_CTRL_MDU_EN
module tb_pipe_ctrl;
  import pipe_pkg::*;

`ifdef PIPE_CTRL_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct packed {
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] tu_rs;
    logic [1:0] tu_rt;
    logic [4:0] e_ra;
    logic [4:0] m_ra;
    logic [1:0] e_tn;
    logic [1:0] m_tn;
    logic d_md, e_st, e_div, eret, e_epc, m_epc, m_req, rst;
  } in_t;

  typedef struct {
    in_t  in;
    logic stall;
    logic req;
  } vec_t;

  logic        clk = 1'b0;
  in_t         cur;
  logic        stall, req, md_busy;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(cur.rst),
    .D_rs(cur.d_rs), .D_rt(cur.d_rt), .D_Tuse_rs(cur.tu_rs), .D_Tuse_rt(cur.tu_rt),
    .E_RegAddr(cur.e_ra), .M_RegAddr(cur.m_ra), .E_Tnew(cur.e_tn), .M_Tnew(cur.m_tn),
    .D_is_md(cur.d_md), .E_md_start(cur.e_st), .E_md_div(cur.e_div), .D_eret(cur.eret),
    .E_mtc0_epc(cur.e_epc), .M_mtc0_epc(cur.m_epc), .M_req(cur.m_req),
    .stall(stall), .req(req), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  int          n_vec = 0;
  int          n_err = 0;
  longint      cyc = 0;
  longint      busy_until = -1;
  logic [31:0] m_scnt = 32'd0;
  logic        obs_stall, obs_req, obs_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic model_raw(input in_t x);
    logic [4:0] src [2];
    logic [1:0] tu  [2];
    logic       hit;
    src = '{x.d_rs, x.d_rt};
    tu  = '{x.tu_rs, x.tu_rt};
    hit = 1'b0;
    for (int i = 0; i < 2; i++)
      if (src[i] != 5'd0 && tu[i] != TUSE_NONE) begin
        if (src[i] == x.e_ra && tu[i] < x.e_tn) hit = 1'b1;
        if (src[i] == x.m_ra && tu[i] < x.m_tn) hit = 1'b1;
      end
    return hit;
  endfunction

  // Checks one cycle at the falling edge, then advances the reference model.
  task automatic run_cycle(input string nm, input bit has_t = 1'b0,
                           input logic ts = 1'b0, input logic tr = 1'b0);
    logic eb, es, er;
    @(negedge clk);
    eb = MDU && !cur.rst && (cur.e_st || cyc <= busy_until);
    es = !cur.rst && !cur.m_req &&
         (model_raw(cur) || (cur.d_md && eb) || (cur.eret && (cur.e_epc || cur.m_epc)));
    er = !cur.rst && cur.m_req;
    obs_stall = stall;
    obs_req   = req;
    obs_busy  = md_busy;
    chk({nm, " stall"}, 32'(stall), 32'(es));
    chk({nm, " req"}, 32'(req), 32'(er));
    chk({nm, " md_busy"}, 32'(md_busy), 32'(eb));
    chk({nm, " stall_cnt"}, stall_cnt, m_scnt);
    if (has_t) begin
      chk({nm, " tbl stall"}, 32'(stall), 32'(ts));
      chk({nm, " tbl req"}, 32'(req), 32'(tr));
    end
    @(posedge clk);
    if (cur.rst) begin
      m_scnt     = 32'd0;
      busy_until = -1;
    end else begin
      if (es && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
      if (MDU && cur.e_st && !cur.m_req)
        busy_until = cyc + longint'(cur.e_div ? DIV_N : MULT_N);
    end
    cyc++;
    #1;
  endtask

  function automatic in_t mk_raw(input logic [4:0] rs, input logic [1:0] trs,
                                 input logic [4:0] rt, input logic [1:0] trt,
                                 input logic [4:0] ea, input logic [1:0] et,
                                 input logic [4:0] ma, input logic [1:0] mt);
    in_t t;
    t = '0;
    t.d_rs = rs; t.tu_rs = trs; t.d_rt = rt; t.tu_rt = trt;
    t.e_ra = ea; t.e_tn = et;   t.m_ra = ma; t.m_tn = mt;
    t.tu_rs = (rs == 5'd0 && trs == 2'd0) ? TUSE_NONE : trs;
    return t;
  endfunction

  task automatic do_reset();
    cur = '0;
    cur.rst = 1'b1;
    run_cycle("reset");
    cur.rst = 1'b0;
  endtask

  vec_t tbl [12];
  int   nst;

  initial begin
    in_t t;
    tbl[0]  = '{mk_raw(5'd8, 2'd1, 5'd0, TUSE_NONE, 5'd8, 2'd2, 5'd0, 2'd0), 1'b1, 1'b0};
    tbl[1]  = '{mk_raw(5'd8, 2'd1, 5'd0, TUSE_NONE, 5'd0, 2'd0, 5'd8, 2'd1), 1'b0, 1'b0};
    t = mk_raw(5'd0, 2'd0, 5'd0, TUSE_NONE, 5'd0, 2'd2, 5'd0, 2'd0);
    t.tu_rs = 2'd0;
    tbl[2]  = '{t, 1'b0, 1'b0};
    tbl[3]  = '{mk_raw(5'd0, TUSE_NONE, 5'd9, 2'd0, 5'd0, 2'd0, 5'd9, 2'd1), 1'b1, 1'b0};
    tbl[4]  = '{mk_raw(5'd0, TUSE_NONE, 5'd9, TUSE_NONE, 5'd9, 2'd3, 5'd0, 2'd0), 1'b0, 1'b0};
    tbl[5]  = '{mk_raw(5'd5, 2'd2, 5'd0, TUSE_NONE, 5'd5, 2'd2, 5'd0, 2'd0), 1'b0, 1'b0};
    tbl[6]  = '{mk_raw(5'd5, 2'd1, 5'd0, TUSE_NONE, 5'd6, 2'd2, 5'd0, 2'd0), 1'b0, 1'b0};
    t = mk_raw(5'd4, 2'd0, 5'd0, TUSE_NONE, 5'd4, 2'd1, 5'd0, 2'd0);
    t.m_req = 1'b1;
    tbl[7]  = '{t, 1'b0, 1'b1};
    t = '0; t.tu_rs = TUSE_NONE; t.tu_rt = TUSE_NONE; t.eret = 1'b1; t.m_epc = 1'b1;
    tbl[8]  = '{t, 1'b1, 1'b0};
    t.m_epc = 1'b0;
    tbl[9]  = '{t, 1'b0, 1'b0};
    t.eret = 1'b0; t.e_epc = 1'b1;
    tbl[10] = '{t, 1'b0, 1'b0};
    tbl[11] = '{mk_raw(5'd0, TUSE_NONE, 5'd31, 2'd0, 5'd0, 2'd0, 5'd31, 2'd3), 1'b1, 1'b0};

    // Reset with every stall/flush/start input asserted: outputs must stay low.
    cur = '0;
    cur.rst = 1'b1; cur.m_req = 1'b1; cur.e_st = 1'b1; cur.d_md = 1'b1;
    cur.eret = 1'b1; cur.m_epc = 1'b1;
    @(posedge clk); #1;
    run_cycle("reset forced");
    run_cycle("reset forced");
    cur.rst = 1'b0;

    foreach (tbl[i]) begin
      cur = tbl[i].in;
      run_cycle($sformatf("tbl%0d", i), 1'b1, tbl[i].stall, tbl[i].req);
    end

    // lw in E then in M
    cur = mk_raw(5'd8, 2'd1, 5'd0, TUSE_NONE, 5'd8, 2'd2, 5'd0, 2'd0);
    run_cycle("t1 lw_in_E");
    chk("t1 stall E", 32'(obs_stall), 32'd1);
    cur = mk_raw(5'd8, 2'd1, 5'd0, TUSE_NONE, 5'd0, 2'd0, 5'd8, 2'd1);
    run_cycle("t1 lw_in_M");
    chk("t1 stall M", 32'(obs_stall), 32'd0);

    // div in E with mflo in D
    do_reset();
    cur = '0; cur.tu_rs = TUSE_NONE; cur.tu_rt = TUSE_NONE;
    cur.e_st = 1'b1; cur.e_div = 1'b1; cur.d_md = 1'b1;
    nst = 0;
    run_cycle("t3 div start");
    nst += int'(obs_stall);
    cur.e_st = 1'b0; cur.e_div = 1'b0;
    repeat (10) begin
      run_cycle("t3 div busy");
      nst += int'(obs_stall);
    end
    run_cycle("t3 div done");
    chk("t3 stall after", 32'(obs_stall), 32'd0);
    chk("t3 stall cycles", 32'(nst), MDU ? 32'd11 : 32'd0);
    chk("t3 stall_cnt", stall_cnt, MDU ? 32'd11 : 32'd0);

    // flush with RAW stall and MDU start in the same cycle
    cur = mk_raw(5'd8, 2'd1, 5'd0, TUSE_NONE, 5'd8, 2'd2, 5'd0, 2'd0);
    cur.e_st = 1'b1; cur.m_req = 1'b1;
    run_cycle("t4 flush");
    chk("t4 req", 32'(obs_req), 32'd1);
    chk("t4 stall", 32'(obs_stall), 32'd0);
    cur = '0; cur.tu_rs = TUSE_NONE; cur.tu_rt = TUSE_NONE; cur.d_md = 1'b1;
    run_cycle("t4 after");
    chk("t4 md_busy after", 32'(obs_busy), 32'd0);

    // eret behind mtc0 EPC
    cur = '0; cur.tu_rs = TUSE_NONE; cur.tu_rt = TUSE_NONE; cur.eret = 1'b1; cur.m_epc = 1'b1;
    run_cycle("t5 eret");
    nst = int'(obs_stall);
    cur.m_epc = 1'b0;
    run_cycle("t5 eret go");
    nst += int'(obs_stall);
    chk("t5 stall cycles", 32'(nst), 32'd1);

    // reset in the middle of a multiply
    do_reset();
    cur = '0; cur.tu_rs = TUSE_NONE; cur.tu_rt = TUSE_NONE; cur.e_st = 1'b1; cur.d_md = 1'b1;
    run_cycle("t6 mult start");
    cur.e_st = 1'b0;
    run_cycle("t6 cnt5");
    run_cycle("t6 cnt4");
    cur.rst = 1'b1;
    run_cycle("t6 reset");
    cur.rst = 1'b0;
    run_cycle("t6 after");
    chk("t6 md_busy", 32'(obs_busy), 32'd0);
    chk("t6 stall", 32'(obs_stall), 32'd0);
    chk("t6 stall_cnt", stall_cnt, 32'd0);

    for (int k = 0; k < 400; k++) begin
      cur.d_rs  = 5'($urandom_range(0, 3));
      cur.d_rt  = 5'($urandom_range(0, 3));
      cur.tu_rs = 2'($urandom_range(0, 3));
      cur.tu_rt = 2'($urandom_range(0, 3));
      cur.e_ra  = 5'($urandom_range(0, 3));
      cur.m_ra  = 5'($urandom_range(0, 3));
      cur.e_tn  = 2'($urandom_range(0, 3));
      cur.m_tn  = 2'($urandom_range(0, 3));
      cur.d_md  = ($urandom_range(0, 1) == 0);
      cur.e_st  = ($urandom_range(0, 5) == 0);
      cur.e_div = ($urandom_range(0, 1) == 0);
      cur.eret  = ($urandom_range(0, 3) == 0);
      cur.e_epc = ($urandom_range(0, 3) == 0);
      cur.m_epc = ($urandom_range(0, 3) == 0);
      cur.m_req = ($urandom_range(0, 7) == 0);
      cur.rst   = ($urandom_range(0, 49) == 0);
      run_cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
